// File: rtl/usb3_fx3_pkg.sv
// Shared definitions for the USB3 / FX3 slave-FIFO datapath: controller
// state encoding, FX3 flag timing and default DMA buffer depths.
package usb3_fx3_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WRITE = 3'd2,
    PAUSE = 3'd3,
    ZLP   = 3'd4
  } fx3_state_e;

  // PCLK cycles from the FX3 sampling SLWR# to its flag reflecting the word.
  localparam int FX3_FLAG_LATENCY = 3;
  // Smallest safe watermark: two in-flight strobes plus the flag latency.
  localparam int FX3_WM_MIN = 2 + FX3_FLAG_LATENCY;

  // DMA buffer depth in 32-bit words for SuperSpeed (1024 B) and HighSpeed (512 B).
  localparam int BUF_WORDS_USB3 = 256;
  localparam int BUF_WORDS_USB2 = 128;

  // The FX3 may only be written when neither full nor almost-full is asserted.
  function automatic logic flags_ok(input logic fa, input logic fb);
    return fa & fb;
  endfunction

endpackage

// File: rtl/axis_fx3_slave_fifo_tx.sv
// AXI4-Stream sink driving the FX3 GPIF II synchronous slave-FIFO write port.
// Every FX3-facing output is a single register so it can be packed in an IOB.
// Build option: define FX3_ZLP_EN to follow a buffer-aligned packet with a
// zero-length packet commit; without it such packets simply auto-commit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released (slcs_n=1); socket address latched on first tvalid
// ADDR  | chip selected, address settling for ADDR_SETUP cycles
// WRITE | streaming; tready follows the registered FX3 flags
// PAUSE | FX3 full or almost full; wait for both flags to clear
// ZLP   | (FX3_ZLP_EN) issue a zero-length commit after an aligned packet
module axis_fx3_slave_fifo_tx
  import usb3_fx3_pkg::*;
#(
  parameter int DQ_WIDTH    = 32,
  parameter int TDEST_WIDTH = 2,
  parameter int BUF_WORDS   = BUF_WORDS_USB3,
  parameter int ADDR_SETUP  = 2
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DQ_WIDTH-1:0]      s_axis_tdata,
  input  logic [DQ_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [TDEST_WIDTH-1:0]   s_axis_tdest,
  output logic [DQ_WIDTH-1:0]      fx3_dq,
  output logic [1:0]               fx3_a,
  output logic                     fx3_slcs_n,
  output logic                     fx3_slwr_n,
  output logic                     fx3_sloe_n,
  output logic                     fx3_slrd_n,
  output logic                     fx3_pktend_n,
  input  logic                     fx3_flaga_n,
  input  logic                     fx3_flagb_n,
  output logic [15:0]              stat_pkt_cnt,
  output logic                     stat_err_partial
);

  localparam int KEEP_W = DQ_WIDTH / 8;
  localparam int CNT_W  = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam logic [CNT_W-1:0] BUF_LAST   = CNT_W'(BUF_WORDS - 1);
  localparam logic [3:0]       SETUP_LOAD = 4'(ADDR_SETUP - 1);

  fx3_state_e          state_q, state_d;
  logic                fa_q, fb_q;
  logic [1:0]          a_q, a_d;
  logic                slcs_n_q, slcs_n_d;
  logic                slwr_n_q, slwr_n_d;
  logic                pktend_n_q, pktend_n_d;
  logic [DQ_WIDTH-1:0] dq_q, dq_d;
  logic [CNT_W-1:0]    buf_cnt_q, buf_cnt_d;
  logic [3:0]          setup_q, setup_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic                err_q, err_d;
  logic [DQ_WIDTH-1:0] beat_dq;
  logic                beat_ok;
  logic                hs;

  // Ready depends only on registered state, so the source sees a clean timing path.
  assign beat_ok       = flags_ok(fa_q, fb_q);
  assign s_axis_tready = (state_q == WRITE) && beat_ok;
  assign hs            = s_axis_tvalid && s_axis_tready;

  // Bytes with tkeep low are driven as zero on the bus.
  always_comb begin
    beat_dq = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_dq[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
    end
  end

  // Next-state and next-output computation for the write sequencer.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    slcs_n_d   = slcs_n_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    dq_d       = dq_q;
    buf_cnt_d  = buf_cnt_q;
    setup_d    = setup_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        // A packet that just ended leaves slcs_n low; release it for a cycle
        // before selecting the next socket.
        slcs_n_d = 1'b1;
        if (s_axis_tvalid && slcs_n_q) begin
          a_d      = s_axis_tdest[1:0];
          slcs_n_d = 1'b0;
          setup_d  = SETUP_LOAD;
          state_d  = ADDR;
        end
      end

      ADDR: begin
        if (setup_q == 4'd0) begin
          state_d = beat_ok ? WRITE : PAUSE;
        end else begin
          setup_d = setup_q - 4'd1;
        end
      end

      WRITE: begin
        if (hs) begin
          dq_d     = beat_dq;
          slwr_n_d = 1'b0;
          if (!(&s_axis_tkeep)) begin
            err_d = 1'b1;
          end
          if (s_axis_tlast) begin
            buf_cnt_d = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (buf_cnt_q != BUF_LAST) begin
              // Short packet: commit explicitly alongside the last word.
              pktend_n_d = 1'b0;
              state_d    = IDLE;
            end else begin
`ifdef FX3_ZLP_EN
              state_d = ZLP;
`else
              state_d = IDLE;
`endif
            end
          end else begin
            buf_cnt_d = (buf_cnt_q == BUF_LAST) ? '0 : buf_cnt_q + CNT_W'(1);
          end
        end else if (!beat_ok) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (beat_ok) begin
          state_d = WRITE;
        end
      end

`ifdef FX3_ZLP_EN
      ZLP: begin
        if (fa_q) begin
          pktend_n_d = 1'b0;
          state_d    = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register flags, FSM state and every FX3 output; reset releases the bus.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      a_q        <= 2'd0;
      slcs_n_q   <= 1'b1;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      dq_q       <= '0;
      buf_cnt_q  <= '0;
      setup_q    <= 4'd0;
      pkt_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fx3_flaga_n;
      fb_q       <= fx3_flagb_n;
      a_q        <= a_d;
      slcs_n_q   <= slcs_n_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      dq_q       <= dq_d;
      buf_cnt_q  <= buf_cnt_d;
      setup_q    <= setup_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

  assign fx3_dq           = dq_q;
  assign fx3_a            = a_q;
  assign fx3_slcs_n       = slcs_n_q;
  assign fx3_slwr_n       = slwr_n_q;
  assign fx3_pktend_n     = pktend_n_q;
  assign fx3_sloe_n       = 1'b1;
  assign fx3_slrd_n       = 1'b1;
  assign stat_pkt_cnt     = pkt_cnt_q;
  assign stat_err_partial = err_q;

endmodule

// File: tb/tb_axis_fx3_slave_fifo_tx.sv
// Self-checking bench for axis_fx3_slave_fifo_tx. A negedge monitor pops the
// scoreboard on every write strobe; scenario tasks check timing and counters.
// Honours FX3_ZLP_EN when the build defines it.
module tb_axis_fx3_slave_fifo_tx;
  import usb3_fx3_pkg::*;

  localparam int DQ_WIDTH    = 32;
  localparam int TDEST_WIDTH = 2;
  localparam int BUF_WORDS   = BUF_WORDS_USB3;
  localparam int ADDR_SETUP  = 2;
`ifdef FX3_ZLP_EN
  localparam int ZLP_EXP = 1;
`else
  localparam int ZLP_EXP = 0;
`endif

  typedef struct packed {
    logic [31:0] dq;
    logic        pktend;
    logic [1:0]  a;
  } exp_t;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   s_axis_tvalid = 1'b0;
  logic                   s_axis_tready;
  logic [DQ_WIDTH-1:0]    s_axis_tdata = '0;
  logic [DQ_WIDTH/8-1:0]  s_axis_tkeep = '1;
  logic                   s_axis_tlast = 1'b0;
  logic [TDEST_WIDTH-1:0] s_axis_tdest = '0;
  logic [DQ_WIDTH-1:0]    fx3_dq;
  logic [1:0]             fx3_a;
  logic                   fx3_slcs_n, fx3_slwr_n, fx3_sloe_n, fx3_slrd_n, fx3_pktend_n;
  logic                   fx3_flaga_n = 1'b1;
  logic                   fx3_flagb_n = 1'b1;
  logic [15:0]            stat_pkt_cnt;
  logic                   stat_err_partial;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   m_buf    = 0;
  int   exp_pkt  = 0;

  // monitor-owned observations
  int          n_wr = 0;
  int          n_zlp = 0;
  int          n_a_viol = 0;
  int          n_cs_fall = 0;
  int          wr_cyc[$];
  int          cs_fall_cyc = 0;
  int          last_gap = 0;
  bit          first_after_cs = 1'b0;
  logic [31:0] last_dq = '0;
  logic [1:0]  prev_a = 2'd0;
  logic        prev_slcs_n = 1'b1;

  axis_fx3_slave_fifo_tx #(
    .DQ_WIDTH   (DQ_WIDTH),
    .TDEST_WIDTH(TDEST_WIDTH),
    .BUF_WORDS  (BUF_WORDS),
    .ADDR_SETUP (ADDR_SETUP)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdest    (s_axis_tdest),
    .fx3_dq          (fx3_dq),
    .fx3_a           (fx3_a),
    .fx3_slcs_n      (fx3_slcs_n),
    .fx3_slwr_n      (fx3_slwr_n),
    .fx3_sloe_n      (fx3_sloe_n),
    .fx3_slrd_n      (fx3_slrd_n),
    .fx3_pktend_n    (fx3_pktend_n),
    .fx3_flaga_n     (fx3_flaga_n),
    .fx3_flagb_n     (fx3_flagb_n),
    .stat_pkt_cnt    (stat_pkt_cnt),
    .stat_err_partial(stat_err_partial)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard monitor: every write strobe must match the next expected word.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      sb.delete();
    end else begin
      if (!fx3_slwr_n) begin
        n_wr++;
        wr_cyc.push_back(cyc);
        if (first_after_cs) begin
          last_gap = cyc - cs_fall_cyc;
          first_after_cs = 1'b0;
        end
        if (!fx3_pktend_n) last_dq = fx3_dq;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL wr_unexpected: strobe with dq=%h but no word expected", fx3_dq);
        end else begin
          e = sb.pop_front();
          if (fx3_dq !== e.dq || fx3_pktend_n !== ~e.pktend || fx3_a !== e.a || fx3_slcs_n !== 1'b0)
            $display("FAIL wr_word: got dq=%h pktend_n=%b a=%0d slcs_n=%b, need dq=%h pktend_n=%b a=%0d slcs_n=0",
                     fx3_dq, fx3_pktend_n, fx3_a, fx3_slcs_n, e.dq, ~e.pktend, e.a);
          else
            n_pass++;
        end
      end else if (!fx3_pktend_n) begin
        n_zlp++;
      end
      if (fx3_a !== prev_a && prev_slcs_n !== 1'b1) n_a_viol++;
      if (!fx3_slcs_n && prev_slcs_n) begin
        n_cs_fall++;
        cs_fall_cyc = cyc;
        first_after_cs = 1'b1;
      end
    end
    prev_a = fx3_a;
    prev_slcs_n = fx3_slcs_n;
  end

  task automatic send_packet(input int len, input logic [1:0] dest, input logic [3:0] last_keep,
                             input logic [31:0] last_data, input bit fixed_last,
                             input int abort_at, output int first_hs);
    int got;
    int wait_c;
    bit hs;
    bit lst;
    logic [31:0] d;
    logic [3:0]  k;
    exp_t e;
    got = 0;
    first_hs = -1;
    while (got < len) begin
      lst = (got == len - 1);
      d = (lst && fixed_last) ? last_data : $urandom;
      k = lst ? last_keep : 4'hF;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = lst;
      s_axis_tdest  = (got == 0) ? dest : 2'($urandom);
      hs = 1'b0;
      wait_c = 0;
      while (!hs && wait_c < 500) begin
        @(negedge aclk);
        hs = s_axis_tready;
        @(posedge aclk);
        wait_c++;
      end
      if (!hs) begin
        n_checks++;
        $display("FAIL beat_timeout: beat %0d of %0d not accepted, need tready within 500 cycles", got, len);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      for (int i = 0; i < 4; i++) e.dq[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
      e.pktend = lst && (m_buf != BUF_WORDS - 1);
      e.a = dest;
      sb.push_back(e);
      m_buf = (lst || m_buf == BUF_WORDS - 1) ? 0 : m_buf + 1;
      got++;
      #1;
      if (first_hs < 0) first_hs = cyc;
      if (got == abort_at) return;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({fx3_slcs_n, fx3_slwr_n, fx3_pktend_n, fx3_sloe_n, fx3_slrd_n, s_axis_tready} !== 6'b111110)
      $display("FAIL reset_ctl: got cs/wr/pe/oe/rd/rdy=%b, need 111110",
               {fx3_slcs_n, fx3_slwr_n, fx3_pktend_n, fx3_sloe_n, fx3_slrd_n, s_axis_tready});
    else n_pass++;
    n_checks++;
    if (fx3_dq !== 32'h0 || fx3_a !== 2'd0) $display("FAIL reset_bus: got dq=%h a=%0d, need 0 0", fx3_dq, fx3_a);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'd0 || stat_err_partial !== 1'b0)
      $display("FAIL reset_stat: got pkt=%0d err=%b, need 0 0", stat_pkt_cnt, stat_err_partial);
    else n_pass++;
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++;
    if (fx3_slcs_n !== 1'b1 || fx3_slwr_n !== 1'b1 || s_axis_tready !== 1'b0)
      $display("FAIL idle_after_reset: got cs=%b wr=%b rdy=%b, need 1 1 0", fx3_slcs_n, fx3_slwr_n, s_axis_tready);
    else n_pass++;
  endtask

  task automatic test_short_packet();
    int base, bi, fh;
    base = n_wr;
    bi = wr_cyc.size();
    send_packet(10, 2'd2, 4'hF, 32'h0, 1'b0, -1, fh);
    exp_pkt++;
    repeat (4) @(negedge aclk);
    n_checks++;
    if (n_wr - base !== 10) $display("FAIL short_count: got %0d writes, need 10", n_wr - base);
    else n_pass++;
    if (n_wr - base == 10) begin
      n_checks++;
      if (wr_cyc[bi] !== fh) $display("FAIL short_latency: first strobe cycle %0d, need %0d", wr_cyc[bi], fh);
      else n_pass++;
      n_checks++;
      if (wr_cyc[bi+9] - wr_cyc[bi] !== 9)
        $display("FAIL short_consecutive: strobes span %0d cycles, need 9", wr_cyc[bi+9] - wr_cyc[bi]);
      else n_pass++;
    end
    n_checks++;
    if (fx3_a !== 2'd2) $display("FAIL short_addr: got a=%0d, need 2", fx3_a);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'(exp_pkt)) $display("FAIL short_pktcnt: got %0d, need %0d", stat_pkt_cnt, exp_pkt);
    else n_pass++;
    n_checks++;
    if (fx3_slcs_n !== 1'b1 || s_axis_tready !== 1'b0)
      $display("FAIL short_release: got cs=%b rdy=%b, need 1 0", fx3_slcs_n, s_axis_tready);
    else n_pass++;
  endtask

  task automatic test_full_buffer();
    int base, zbase, fh;
    base = n_wr;
    zbase = n_zlp;
    send_packet(BUF_WORDS, 2'd1, 4'hF, 32'h0, 1'b0, -1, fh);
    exp_pkt++;
    repeat (8) @(negedge aclk);
    n_checks++;
    if (n_wr - base !== BUF_WORDS) $display("FAIL full_count: got %0d writes, need %0d", n_wr - base, BUF_WORDS);
    else n_pass++;
    n_checks++;
    if (n_zlp - zbase !== ZLP_EXP) $display("FAIL full_zlp: got %0d zero-length commits, need %0d", n_zlp - zbase, ZLP_EXP);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'(exp_pkt)) $display("FAIL full_pktcnt: got %0d, need %0d", stat_pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_throttle();
    int base, fh, at_fall, after, bad, w;
    bit reached;
    base = n_wr;
    at_fall = 0;
    after = 0;
    bad = 0;
    reached = 1'b0;
    fork
      send_packet(600, 2'd0, 4'hF, 32'h0, 1'b0, -1, fh);
      begin
        w = 0;
        while (n_wr - base < 100 && w < 5000) begin
          @(posedge aclk);
          w++;
        end
        reached = (n_wr - base >= 100);
        #1 fx3_flagb_n = 1'b0;
        at_fall = n_wr;
        for (int k = 1; k <= 20; k++) begin
          @(negedge aclk);
          if (k >= 2 && s_axis_tready) bad++;
        end
        @(posedge aclk);
        #1 after = n_wr - at_fall;
        fx3_flagb_n = 1'b1;
      end
    join
    exp_pkt++;
    repeat (6) @(negedge aclk);
    n_checks++;
    if (!reached) $display("FAIL thr_start: got %0d writes before timeout, need 100", n_wr - base);
    else n_pass++;
    n_checks++;
    if (after > 2) $display("FAIL thr_strobes: got %0d strobes after flagb fell, need <= 2", after);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL thr_ready: tready high in %0d cycles of the almost-full window, need 0", bad);
    else n_pass++;
    n_checks++;
    if (n_wr - base !== 600) $display("FAIL thr_count: got %0d writes, need 600", n_wr - base);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL thr_drain: %0d words outstanding, need 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_partial_keep();
    int fh;
    send_packet(3, 2'd1, 4'b0011, 32'hAABBCCDD, 1'b1, -1, fh);
    exp_pkt++;
    repeat (4) @(negedge aclk);
    n_checks++;
    if (last_dq !== 32'h0000CCDD) $display("FAIL keep_mask: got dq=%h, need 0000ccdd", last_dq);
    else n_pass++;
    n_checks++;
    if (stat_err_partial !== 1'b1) $display("FAIL keep_err: got %b, need 1", stat_err_partial);
    else n_pass++;
    send_packet(2, 2'd0, 4'hF, 32'h0, 1'b0, -1, fh);
    exp_pkt++;
    repeat (4) @(negedge aclk);
    n_checks++;
    if (stat_err_partial !== 1'b1) $display("FAIL keep_sticky: got %b, need 1", stat_err_partial);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int base, fh;
    send_packet(10, 2'd1, 4'hF, 32'h0, 1'b0, 5, fh);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_buf = 0;
    exp_pkt = 0;
    #1;
    n_checks++;
    if (fx3_slwr_n !== 1'b1 || fx3_slcs_n !== 1'b1 || s_axis_tready !== 1'b0)
      $display("FAIL rst_async: got wr=%b cs=%b rdy=%b, need 1 1 0", fx3_slwr_n, fx3_slcs_n, s_axis_tready);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'd0 || stat_err_partial !== 1'b0)
      $display("FAIL rst_stat: got pkt=%0d err=%b, need 0 0", stat_pkt_cnt, stat_err_partial);
    else n_pass++;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    base = n_wr;
    send_packet(4, 2'd2, 4'hF, 32'h0, 1'b0, -1, fh);
    exp_pkt++;
    repeat (4) @(negedge aclk);
    n_checks++;
    if (n_wr - base !== 4) $display("FAIL rst_next_count: got %0d writes, need 4", n_wr - base);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'(exp_pkt)) $display("FAIL rst_next_pktcnt: got %0d, need %0d", stat_pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int viol0, fall0, fh;
    viol0 = n_a_viol;
    fall0 = n_cs_fall;
    send_packet(6, 2'd0, 4'hF, 32'h0, 1'b0, -1, fh);
    send_packet(5, 2'd3, 4'hF, 32'h0, 1'b0, -1, fh);
    exp_pkt += 2;
    repeat (4) @(negedge aclk);
    n_checks++;
    if (n_a_viol - viol0 !== 0) $display("FAIL b2b_addr: fx3_a changed %0d times under slcs_n=0, need 0", n_a_viol - viol0);
    else n_pass++;
    n_checks++;
    if (n_cs_fall - fall0 !== 2) $display("FAIL b2b_cs: got %0d chip-select assertions, need 2", n_cs_fall - fall0);
    else n_pass++;
    n_checks++;
    if (last_gap < ADDR_SETUP) $display("FAIL b2b_setup: got %0d cycles before first write, need >= %0d", last_gap, ADDR_SETUP);
    else n_pass++;
    n_checks++;
    if (fx3_a !== 2'd3) $display("FAIL b2b_dest: got a=%0d, need 3", fx3_a);
    else n_pass++;
    n_checks++;
    if (stat_pkt_cnt !== 16'(exp_pkt)) $display("FAIL b2b_pktcnt: got %0d, need %0d", stat_pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  initial begin
    $display("watermark >= %0d words (flag latency %0d); buffer %0d words (USB2 %0d)",
             FX3_WM_MIN, FX3_FLAG_LATENCY, BUF_WORDS, BUF_WORDS_USB2);
    test_reset();
    test_short_packet();
    test_full_buffer();
    test_throttle();
    test_partial_keep();
    test_reset_mid_packet();
    test_back_to_back();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL final_drain: %0d words never written, need 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
